// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg
//   Shared types and constants for the IF-stage fetch unit.
//   - IF_WIDTH / IF_ILEN / IF_BUF_DEPTH : default address width, instruction
//     width and credit limit of the fetch unit.
//   - cnt_w()       : width of a counter that must hold 0..depth inclusive.
//   - CNT_W         : counter width for the default credit limit.
//   - fetch_entry_t : one buffered instruction together with its PC.
// ---------------------------------------------------------------------------
package if_pkg;

    localparam int IF_WIDTH     = 32;
    localparam int IF_ILEN      = 32;
    localparam int IF_BUF_DEPTH = 2;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int CNT_W = cnt_w(IF_BUF_DEPTH);

    typedef struct packed {
        logic [IF_WIDTH-1:0] pc;
        logic [IF_ILEN-1:0]  instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//   Small synchronous FIFO used for the pending-PC queue and the output
//   buffer of the fetch unit.
//   Ports:
//     clk, reset  clock, asynchronous active-high reset (storage zeroed)
//     clear       drop all entries; wins over push/pop in the same cycle
//     push        write push_data at the tail (ignored when full, unless a
//                 pop frees the slot in the same cycle)
//     push_data   entry to write
//     pop         remove the head entry (ignored when empty)
//     head        current head entry (stale data when count == 0)
//     count       number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_fifo
    import if_pkg::*;
#(
    parameter type T     = logic,
    parameter int  DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    output T                         head,
    output logic [cnt_w(DEPTH)-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = cnt_w(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
//   Fetch side of the IF stage. Takes the PC register output, issues in-order
//   instruction-memory reads, and buffers returned words toward ID. Holds the
//   PC register (pc_hold -> update_n) unless a request is accepted or a
//   redirect happens. On flush, every response still in flight is discarded.
//
//   Ports:
//     clk, reset      clock, asynchronous active-high reset
//     pc_addr         current PC from the PC register
//     pc_hold         1 = PC register holds, 0 = PC loads next/redirect target
//     flush           redirect this cycle
//     imem_req_*      read request (valid/ready/addr), addr = pc_addr
//     imem_rsp_*      read response, in order, no backpressure
//     id_valid/ready  instruction handshake toward ID
//     id_instr, id_pc head of the output buffer
//
//   Handshakes: a transfer happens on a rising clk edge where valid && ready
//   are both high; valid never depends on ready of the same interface. The
//   imem response side has no ready: the credit rule guarantees a free slot.
//
//   WIDTH/ILEN must match IF_WIDTH/IF_ILEN because buffered entries use
//   fetch_entry_t from if_pkg.
// ---------------------------------------------------------------------------
module if_fetch
    import if_pkg::*;
#(
    parameter int WIDTH     = IF_WIDTH,
    parameter int ILEN      = IF_ILEN,
    parameter int BUF_DEPTH = IF_BUF_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_addr,
    output logic             pc_hold,
    input  logic             flush,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [ILEN-1:0]  imem_rsp_data,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [ILEN-1:0]  id_instr,
    output logic [WIDTH-1:0] id_pc
);

    // Counter width: the package constant for the default depth.
    localparam int CW  = (BUF_DEPTH == IF_BUF_DEPTH) ? CNT_W : cnt_w(BUF_DEPTH);
    localparam int CW1 = CW + 1;

    logic [CW-1:0]    inflight;
    logic [CW-1:0]    discard;
    logic [CW-1:0]    inflight_next;
    logic [CW-1:0]    pend_count;
    logic [CW-1:0]    buf_count;
    logic [CW:0]      occupancy;
    logic             req_fire;
    logic             rsp_keep;
    logic             id_fire;
    logic [WIDTH-1:0] pend_head;
    fetch_entry_t     buf_in;
    fetch_entry_t     buf_head;

    // Slots already committed: responses we will keep plus buffered words.
    // Only issuing below BUF_DEPTH means a kept response always finds room.
    assign occupancy      = {1'b0, inflight - discard} + {1'b0, buf_count};
    assign imem_req_valid = !reset && !flush && (occupancy < CW1'(BUF_DEPTH));
    assign imem_req_addr  = pc_addr;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign pc_hold        = !(req_fire || flush);

    assign rsp_keep = imem_rsp_valid && (discard == '0);

    // A squashed ID does not consume the head on a flush cycle.
    assign id_valid = (buf_count != '0);
    assign id_fire  = id_valid && id_ready && !flush;
    assign id_instr = buf_head.instr;
    assign id_pc    = buf_head.pc;

    assign inflight_next = inflight + CW'(req_fire) - CW'(imem_rsp_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= '0;
            discard  <= '0;
        end else begin
            inflight <= inflight_next;
            if (flush) begin
                // Everything still outstanding after this edge is stale.
                discard <= inflight_next;
            end else if (imem_rsp_valid && (discard != '0)) begin
                discard <= discard - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .T     (logic [WIDTH-1:0]),
        .DEPTH (BUF_DEPTH)
    ) u_pend (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (req_fire),
        .push_data (pc_addr),
        .pop       (rsp_keep),
        .head      (pend_head),
        .count     (pend_count)
    );

    assign buf_in = '{pc: pend_head, instr: imem_rsp_data};

    // A kept response arriving with a flush is dropped with the rest.
    fetch_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (BUF_DEPTH)
    ) u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (rsp_keep && !flush),
        .push_data (buf_in),
        .pop       (id_fire),
        .head      (buf_head),
        .count     (buf_count)
    );

    always @(posedge clk) begin
        if (!reset) begin
            assert (inflight <= CW'(BUF_DEPTH));
            assert (!(imem_rsp_valid && (inflight == '0)));
            assert (pend_count == inflight - discard);
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

    localparam int W     = 32;
    localparam int DEPTH = 2;
    localparam int NS    = 64;

    logic         clk;
    logic         reset;
    logic [W-1:0] pc_addr;
    logic         pc_hold;
    logic         flush;
    logic         imem_req_valid;
    logic         imem_req_ready;
    logic [W-1:0] imem_req_addr;
    logic         imem_rsp_valid;
    logic [W-1:0] imem_rsp_data;
    logic         id_valid;
    logic         id_ready;
    logic [W-1:0] id_instr;
    logic [W-1:0] id_pc;

    if_fetch #(.WIDTH(W), .ILEN(W), .BUF_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_addr        (pc_addr),
        .pc_hold        (pc_hold),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, got running, expected finished");
        $fatal(1);
    end

    // ---------------- bench state ----------------
    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int lat         = 1;

    logic [W-1:0] pc_reg;              // PC register model (environment)
    logic [W-1:0] mem_addr_q[$];       // memory: accepted addresses
    int           mem_due_q[$];        // memory: cycle each response is due

    // Reference model: requests in flight (with a stale flag) and the words
    // waiting for ID, kept as plain queues.
    logic [W-1:0] fly_pc_q[$];
    bit           fly_drop_q[$];
    logic [W-1:0] exp_q[$];            // expected PCs in front of ID
    logic [W-1:0] exp_ins_q[$];        // matching instruction words

    // Per-cycle samples of DUT outputs, for hand-computed checks.
    logic         s_id_valid  [NS];
    logic [W-1:0] s_id_pc     [NS];
    logic [W-1:0] s_id_instr  [NS];
    logic         s_hold      [NS];
    logic         s_req_valid [NS];
    logic [W-1:0] s_req_addr  [NS];

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset          = 1'b1;
        flush          = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        mem_addr_q.delete();
        mem_due_q.delete();
        fly_pc_q.delete();
        fly_drop_q.delete();
        exp_q.delete();
        exp_ins_q.delete();
        pc_reg  = '0;
        pc_addr = '0;
        @(negedge clk);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_pc_hold", pc_hold, 1);
        chk("rst_id_instr", id_instr, 0);
        chk("rst_id_pc", id_pc, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    // One clock cycle: drive inputs, compare against the model at the
    // negedge, then advance model, memory and PC register across the edge.
    task automatic tick(input logic f, input logic [W-1:0] tgt);
        int           live;
        logic         ev;
        logic         efire;
        logic         eidv;
        logic [W-1:0] p;
        bit           d;

        flush = f;
        if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end

        @(negedge clk);
        live = 0;
        foreach (fly_drop_q[i]) if (!fly_drop_q[i]) live++;
        ev    = !f && ((live + exp_q.size()) < DEPTH);
        efire = ev && imem_req_ready;
        eidv  = exp_q.size() > 0;

        chk("imem_req_valid", imem_req_valid, ev);
        chk("pc_hold", pc_hold, !(efire || f));
        chk("imem_req_addr", imem_req_addr, pc_reg);
        chk("id_valid", id_valid, eidv);
        if (eidv) begin
            chk("id_pc", id_pc, exp_q[0]);
            chk("id_instr", id_instr, exp_ins_q[0]);
        end

        if (cyc < NS) begin
            s_id_valid[cyc]  = id_valid;
            s_id_pc[cyc]     = id_pc;
            s_id_instr[cyc]  = id_instr;
            s_hold[cyc]      = pc_hold;
            s_req_valid[cyc] = imem_req_valid;
            s_req_addr[cyc]  = imem_req_addr;
        end

        if (eidv && id_ready && !f) begin
            void'(exp_q.pop_front());
            void'(exp_ins_q.pop_front());
        end
        if (imem_rsp_valid && fly_pc_q.size() > 0) begin
            p = fly_pc_q.pop_front();
            d = fly_drop_q.pop_front();
            if (!d && !f) begin
                exp_q.push_back(p);
                exp_ins_q.push_back(mem_word(p));
            end
        end
        if (efire) begin
            fly_pc_q.push_back(pc_reg);
            fly_drop_q.push_back(1'b0);
        end
        if (f) begin
            exp_q.delete();
            exp_ins_q.delete();
            foreach (fly_drop_q[i]) fly_drop_q[i] = 1'b1;
        end

        if (imem_req_valid && imem_req_ready) begin
            mem_addr_q.push_back(imem_req_addr);
            mem_due_q.push_back(cyc + lat);
        end
        if (!pc_hold) pc_reg = f ? tgt : pc_reg + 32'd4;

        @(posedge clk);
        #1;
        pc_addr = pc_reg;
        cyc++;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int n;
        int guard;
        int base;

        reset          = 1'b1;
        flush          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        id_ready       = 1'b0;
        pc_addr        = '0;
        pc_reg         = '0;

        // 1: streaming fetch from PC 0, 1-cycle memory, ID always ready
        do_reset();
        lat = 1; imem_req_ready = 1'b1; id_ready = 1'b1;
        repeat (8) tick(1'b0, '0);
        chk("t1_hold_c0", s_hold[0], 0);
        chk("t1_addr_c1", s_req_addr[1], 32'h4);
        chk("t1_idv_c1", s_id_valid[1], 0);
        chk("t1_idv_c2", s_id_valid[2], 1);
        chk("t1_idpc_c2", s_id_pc[2], 32'h0);
        chk("t1_instr_c2", s_id_instr[2], 32'hC0DE_0000);
        chk("t1_idpc_c3", s_id_pc[3], 32'h4);
        chk("t1_idpc_c5", s_id_pc[5], 32'h8);

        // 2: ID stalled, credit stops after two requests
        do_reset();
        lat = 1; imem_req_ready = 1'b1; id_ready = 1'b0;
        repeat (6) tick(1'b0, '0);
        n = 0;
        for (int i = 0; i < 6; i++) n += int'(s_req_valid[i]);
        chk("t2_fires", n, 2);
        chk("t2_valid_c5", s_req_valid[5], 0);
        chk("t2_hold_c5", s_hold[5], 1);
        id_ready = 1'b1;
        repeat (4) tick(1'b0, '0);
        chk("t2_valid_c6", s_req_valid[6], 0);
        chk("t2_valid_c7", s_req_valid[7], 1);
        chk("t2_addr_c7", s_req_addr[7], 32'h8);

        // 3: memory not ready for 3 cycles at PC 0x10
        do_reset();
        lat = 1; imem_req_ready = 1'b1; id_ready = 1'b1;
        guard = 0;
        while (pc_reg != 32'h10 && guard < 20) begin
            tick(1'b0, '0);
            guard++;
        end
        chk("t3_reach_pc", pc_reg, 32'h10);
        imem_req_ready = 1'b0;
        base = cyc;
        repeat (3) tick(1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold", s_hold[base + i], 1);
            chk("t3_addr", s_req_addr[base + i], 32'h10);
        end
        imem_req_ready = 1'b1;
        repeat (4) tick(1'b0, '0);

        // 4: flush with two requests in flight, redirect to 0x100
        do_reset();
        lat = 3; imem_req_ready = 1'b1; id_ready = 1'b1;
        tick(1'b0, '0);
        tick(1'b0, '0);
        tick(1'b1, 32'h100);
        repeat (6) tick(1'b0, '0);
        chk("t4_flush_valid", s_req_valid[2], 0);
        chk("t4_flush_hold", s_hold[2], 0);
        chk("t4_addr_c3", s_req_addr[3], 32'h100);
        for (int i = 3; i < 7; i++) chk("t4_idv_quiet", s_id_valid[i], 0);
        chk("t4_idv_c7", s_id_valid[7], 1);
        chk("t4_idpc_c7", s_id_pc[7], 32'h100);

        // 5: flush coincides with a response and id_ready
        do_reset();
        lat = 1; imem_req_ready = 1'b1; id_ready = 1'b0;
        tick(1'b0, '0);
        tick(1'b0, '0);
        id_ready = 1'b1;
        tick(1'b1, 32'h200);
        repeat (4) tick(1'b0, '0);
        chk("t5_head_valid", s_id_valid[2], 1);
        chk("t5_head_pc", s_id_pc[2], 32'h0);
        chk("t5_idv_c3", s_id_valid[3], 0);
        chk("t5_idv_c4", s_id_valid[4], 0);
        chk("t5_addr_c3", s_req_addr[3], 32'h200);
        chk("t5_idv_c5", s_id_valid[5], 1);
        chk("t5_idpc_c5", s_id_pc[5], 32'h200);

        // 6: asynchronous reset in the middle of a burst
        do_reset();
        lat = 2; imem_req_ready = 1'b1; id_ready = 1'b1;
        repeat (4) tick(1'b0, '0);
        flush = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_req_valid", imem_req_valid, 0);
        chk("t6_id_valid", id_valid, 0);
        chk("t6_pc_hold", pc_hold, 1);
        chk("t6_id_pc", id_pc, 0);
        chk("t6_id_instr", id_instr, 0);
        do_reset();
        repeat (5) tick(1'b0, '0);
        chk("t6_addr_c0", s_req_addr[0], 32'h0);
        chk("t6_idv_c2", s_id_valid[2], 0);
        chk("t6_idv_c3", s_id_valid[3], 1);
        chk("t6_idpc_c3", s_id_pc[3], 32'h0);
        chk("t6_instr_c3", s_id_instr[3], 32'hC0DE_0000);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
